td4_front_panel: RTL and testbench
==================================

Name: td4_front_panel

Overview:
- Parametrised front panel for the TD4 FPGA computer.
- Generates the CPU clock-enable in four modes: halt, single-step, run and fast-run.
- Debounces the step button and converts a DATA_WIDTH-bit CPU output to decimal through a sequential double-dabble converter.
- Drives N_DIGITS active-low 7-segment digits. Instantiated between board I/O and mother_board.

Parameters:
- DATA_WIDTH, 8: width of the displayed CPU output value.
- N_DIGITS, 3: number of 7-segment digits driven.
- RATIO, 50_000_000: clock cycles per cpu_tick in RUN mode (at least 2).
- FAST_DIV, 16: RATIO divisor used in FAST mode. The effective period is max(RATIO/FAST_DIV, 1).
- DEBOUNCE_CYCLES, 1_000_000: cycles the synchronised button must be stable before it is accepted.
- BLANK_LZ, 1: 1 = blank leading zeros; digit 0 is never blanked.

Ports:
- clock, in, 1: system clock. The block has one clock.
- reset, in, 1: synchronous, active-high reset.
- mode, in, 2: 00 HALT, 01 STEP, 10 RUN, 11 FAST.
- step_btn, in, 1: raw, asynchronous push button, active-high.
- data_in, in, DATA_WIDTH: value to display (unsigned).
- cpu_tick, out, 1: one-cycle clock-enable pulse to the CPU.
- tick_led, out, 1: toggles on every cpu_tick; debug LED.
- hex, out, 7*N_DIGITS: segments. hex[6:0] is digit 0 (ones); bit0=a through bit6=g; active-low.
- busy, out, 1: high while a BCD conversion is in progress.

Behaviour:
- Reset (synchronous, active-high; clock is the only clock)
  - cpu_tick=0, tick_led=0, busy=0.
  - hex shows all digits blank (7'h7F).
  - Divider and debounce counters clear; debounced level clears to 0.
  - Reset asserted mid-conversion aborts the conversion. The first new conversion starts on the cycle after reset deasserts.
- Button path
  - 2-flop synchroniser, then a debounce counter.
  - The debounced level changes only after the synchronised input has differed from it for DEBOUNCE_CYCLES consecutive cycles. Any bounce restarts the counter.
  - step_pulse = one-cycle pulse on the debounced rising edge.
- Tick generation
  - HALT: cpu_tick is never asserted; the divider is held at 0.
  - STEP: cpu_tick = step_pulse. Exactly one tick per accepted press, no matter how long the button is held.
  - RUN: the divider counts 0..RATIO-1. cpu_tick is asserted in the cycle the count equals RATIO-1. First tick comes RATIO cycles after entering the mode.
  - FAST: same as RUN with period max(RATIO/FAST_DIV, 1). A period of 1 gives cpu_tick constantly high.
  - A mode change (mode differs from its registered previous value) clears the divider in that cycle and suppresses the tick in that cycle.
  - step_pulse is ignored outside STEP mode.
- tick_led inverts on every cycle in which cpu_tick=1.
- Conversion (sub-module), FSM IDLE -> SHIFT -> DONE -> IDLE
  - IDLE: latch data_in into the shift register, clear the BCD register, busy=1, go to SHIFT.
  - SHIFT: DATA_WIDTH iterations. Each iteration adds 3 to every BCD nibble >=5, then shifts left one bit.
  - DONE: transfer the BCD register to the display register, busy=0 for this one cycle, then return to IDLE.
  - Runs continuously. Update latency from data_in change to hex is at most 2*(DATA_WIDTH+2) cycles.
  - Internal BCD digit count INT_DIGITS = (DATA_WIDTH+2)/3 + 1. This is always enough to hold 2^DATA_WIDTH-1.
- Display
  - Overflow: if any internal digit at index >= N_DIGITS is nonzero, all N_DIGITS show dash (7'b0111111).
  - Otherwise digit i shows the standard hex-font glyph of BCD nibble i.
  - With BLANK_LZ=1, leading zero digits above digit 0 are blanked.
  - hex is driven from registered display state; no combinational path from data_in.

Decomposition:
- Package td4_panel_pkg:
  - typedef enum logic [1:0] panel_mode_t {HALT, STEP, RUN, FAST}.
  - Constants SEG_BLANK=7'h7F and SEG_DASH=7'b0111111.
  - Function seg_of(logic [3:0]) returning active-low segments.
  - Conversion FSM state enum.
- Sub-module bin2bcd_seq: the sequential double-dabble converter.
  - Parameters WIDTH and DIGITS.
  - Ports clock, reset, bin, bcd, done, busy.
- Debouncer, tick generator and display formatting stay in td4_front_panel.

Test Plan (RATIO=4, FAST_DIV=2, DEBOUNCE_CYCLES=3, DATA_WIDTH=8, N_DIGITS=3):
- Reset, then mode=RUN for 20 cycles -> cpu_tick pulses at cycles 4, 8, 12, 16, 20 after reset release. tick_led ends at 1. Switch to FAST -> period becomes 2, first tick 2 cycles after the switch.
- mode=STEP, step_btn bouncing 1,0,1,0 then held high 10 cycles -> exactly one cpu_tick, occurring 2+3 cycles after the stable edge. Release and press again -> a second tick.
- mode=HALT, step_btn pressed and RUN-length wait -> no cpu_tick.
- data_in=8'd205 -> within 20 cycles hex = {seg(2), seg(0), seg(5)}. data_in=8'd7 -> {BLANK, BLANK, seg(7)}. data_in=0 -> {BLANK, BLANK, seg(0)}.
- N_DIGITS=2 and data_in=8'd255 -> both digits show SEG_DASH. data_in=99 -> {seg(9), seg(9)}.
- Assert reset mid-conversion (busy=1) -> next cycle hex is all SEG_BLANK, busy=0, cpu_tick=0. After release the correct value appears within 2*(DATA_WIDTH+2) cycles.

Source files
------------

// File: rtl/td4_panel_pkg.sv
// Shared types, segment constants and glyph lookup for the TD4 front panel.
// Latency: none; types, constants and a pure function only.
// Backpressure: not applicable.
package td4_panel_pkg;

  typedef enum logic [1:0] {
    HALT = 2'b00,
    STEP = 2'b01,
    RUN  = 2'b10,
    FAST = 2'b11
  } panel_mode_t;

  typedef enum logic [1:0] {
    CONV_IDLE  = 2'b00,
    CONV_SHIFT = 2'b01,
    CONV_DONE  = 2'b10
  } conv_state_t;

  // Segments are active-low, bit0 = a ... bit6 = g.
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // Standard hex-font glyph for one nibble.
  function automatic logic [6:0] seg_of(input logic [3:0] nib);
    logic [6:0] seg;
    seg = SEG_BLANK;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, free-running.
// Latency: WIDTH+2 cycles per conversion (latch, WIDTH shifts, done).
// Backpressure: none; result is valid only in the cycle done is high.
module bin2bcd_seq
  import td4_panel_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = (WIDTH + 2) / 3 + 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      bin,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  done,
  output logic                  busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_IT = CNT_W'(WIDTH - 1);

  conv_state_t          state_q, state_d;
  logic [WIDTH-1:0]     sh_q, sh_d;
  logic [4*DIGITS-1:0]  bcd_q, bcd_d;
  logic [4*DIGITS-1:0]  adj;
  logic [CNT_W-1:0]     it_q, it_d;

  // Add 3 to every nibble that would overflow past 9 after the next shift.
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // Next-state logic: latch input, shift WIDTH times, present result for one cycle.
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    bcd_d   = bcd_q;
    it_d    = it_q;
    case (state_q)
      CONV_IDLE: begin
        sh_d    = bin;
        bcd_d   = '0;
        it_d    = '0;
        state_d = CONV_SHIFT;
      end
      CONV_SHIFT: begin
        {bcd_d, sh_d} = {adj, sh_q} << 1;
        it_d          = it_q + CNT_W'(1);
        if (it_q == LAST_IT) state_d = CONV_DONE;
      end
      CONV_DONE: state_d = CONV_IDLE;
      default:   state_d = CONV_IDLE;
    endcase
  end

  // State registers; reset aborts any conversion and restarts from IDLE.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= CONV_IDLE;
      sh_q    <= '0;
      bcd_q   <= '0;
      it_q    <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      bcd_q   <= bcd_d;
      it_q    <= it_d;
    end
  end

  assign bcd  = bcd_q;
  assign done = (state_q == CONV_DONE);
  // Held low during reset so the first conversion is visible only once reset drops.
  assign busy = !reset && (state_q != CONV_DONE);

endmodule

// File: rtl/td4_front_panel.sv
// TD4 front panel: CPU clock-enable in four modes, step-button debounce, decimal display.
// Latency: step tick 2+DEBOUNCE_CYCLES cycles after press; hex within 2*(DATA_WIDTH+2) cycles.
// Backpressure: none; the CPU takes every cpu_tick and the display is simply overwritten.
module td4_front_panel
  import td4_panel_pkg::*;
#(
  parameter int DATA_WIDTH      = 8,
  parameter int N_DIGITS        = 3,
  parameter int RATIO           = 50_000_000,
  parameter int FAST_DIV        = 16,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int BLANK_LZ        = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [1:0]              mode,
  input  logic                    step_btn,
  input  logic [DATA_WIDTH-1:0]   data_in,
  output logic                    cpu_tick,
  output logic                    tick_led,
  output logic [7*N_DIGITS-1:0]   hex,
  output logic                    busy
);

  localparam int INT_DIGITS  = (DATA_WIDTH + 2) / 3 + 1;
  localparam int ALL_DIGITS  = (INT_DIGITS > N_DIGITS) ? INT_DIGITS : N_DIGITS;
  localparam int FAST_RAW    = RATIO / FAST_DIV;
  localparam int FAST_PERIOD = (FAST_RAW < 1) ? 1 : FAST_RAW;
  localparam int DIV_W       = $clog2(RATIO);
  localparam logic [DIV_W-1:0] RUN_LAST  = DIV_W'(RATIO - 1);
  localparam logic [DIV_W-1:0] FAST_LAST = DIV_W'(FAST_PERIOD - 1);
  localparam int DB_W        = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  // Button path
  logic              sync1_q, sync2_q;
  logic              db_q, db_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic              step_pulse_q, step_pulse_d;

  // Tick generation
  panel_mode_t       mode_cur, mode_prev_q;
  logic              mode_chg;
  logic [DIV_W-1:0]  div_q, div_d, div_last;
  logic              tick_led_q;

  // Display
  logic [4*INT_DIGITS-1:0] bcd_w;
  logic [4*ALL_DIGITS-1:0] bcd_ext;
  logic                    conv_done;
  logic                    ovf;
  logic [7*N_DIGITS-1:0]   hex_d, hex_q;

  // Debounce: accept the synchronised level only after it has differed for DEBOUNCE_CYCLES cycles.
  always_comb begin
    db_cnt_d = '0;
    db_d     = db_q;
    if (sync2_q != db_q) begin
      if (db_cnt_q == DB_LAST) db_d = sync2_q;
      else                     db_cnt_d = db_cnt_q + DB_W'(1);
    end
  end

  assign step_pulse_d = db_d & ~db_q;

  assign mode_cur = panel_mode_t'(mode);
  assign mode_chg = (mode_cur != mode_prev_q);
  assign div_last = (mode_cur == FAST) ? FAST_LAST : RUN_LAST;

  // Divider and tick select; a mode change clears the divider and swallows that cycle's tick.
  always_comb begin
    div_d    = '0;
    cpu_tick = 1'b0;
    if (!mode_chg) begin
      case (mode_cur)
        STEP: cpu_tick = step_pulse_q;
        RUN, FAST: begin
          if (div_q >= div_last) cpu_tick = 1'b1;
          else                   div_d    = div_q + DIV_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Button synchroniser, debounce state, divider and LED registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      db_q         <= 1'b0;
      db_cnt_q     <= '0;
      step_pulse_q <= 1'b0;
      mode_prev_q  <= HALT;
      div_q        <= '0;
      tick_led_q   <= 1'b0;
    end else begin
      sync1_q      <= step_btn;
      sync2_q      <= sync1_q;
      db_q         <= db_d;
      db_cnt_q     <= db_cnt_d;
      step_pulse_q <= step_pulse_d;
      mode_prev_q  <= mode_cur;
      div_q        <= div_d;
      if (cpu_tick) tick_led_q <= ~tick_led_q;
    end
  end

  bin2bcd_seq #(
    .WIDTH  (DATA_WIDTH),
    .DIGITS (INT_DIGITS)
  ) u_bcd (
    .clock (clock),
    .reset (reset),
    .bin   (data_in),
    .bcd   (bcd_w),
    .done  (conv_done),
    .busy  (busy)
  );

  assign bcd_ext = (4*ALL_DIGITS)'(bcd_w);

  // Format the finished BCD value: overflow dashes, leading-zero blanking, glyph lookup.
  always_comb begin
    logic lz_run;
    ovf    = 1'b0;
    lz_run = (BLANK_LZ != 0);
    hex_d  = '0;
    for (int i = N_DIGITS; i < ALL_DIGITS; i++) begin
      if (bcd_ext[4*i +: 4] != 4'd0) ovf = 1'b1;
    end
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      if (i > 0 && lz_run && bcd_ext[4*i +: 4] == 4'd0) begin
        hex_d[7*i +: 7] = SEG_BLANK;
      end else begin
        lz_run          = 1'b0;
        hex_d[7*i +: 7] = seg_of(bcd_ext[4*i +: 4]);
      end
      if (ovf) hex_d[7*i +: 7] = SEG_DASH;
    end
  end

  // Display register: loaded only when a conversion completes, blank out of reset.
  always_ff @(posedge clock) begin
    if (reset)          hex_q <= {N_DIGITS{SEG_BLANK}};
    else if (conv_done) hex_q <= hex_d;
  end

  assign hex      = hex_q;
  assign tick_led = tick_led_q;

endmodule

// File: tb/tb_td4_front_panel.sv
// Self-checking bench for td4_front_panel: 3-digit and 2-digit instances share all inputs.
// Expected tick cycles and display glyphs are queued at stimulus time and popped on output.
// Inputs are driven 1ns after the rising edge; ticks are sampled on the falling edge.
module tb_td4_front_panel;

  localparam int BL = 10;  // blank glyph code
  localparam int DS = 11;  // dash glyph code

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  mode;
  logic        step_btn;
  logic [7:0]  data_in;
  logic        cpu_tick, tick_led, busy;
  logic [20:0] hex;
  logic        cpu_tick2, tick_led2, busy2;
  logic [13:0] hex2;

  int cyc = 0;
  int n_assert = 0;
  int n_fail = 0;
  int t0;

  int          exp_t[$];
  int          obs_t1[$];
  int          obs_t2[$];
  logic [20:0] exp_h1[$];
  logic [13:0] exp_h2[$];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  td4_front_panel #(
    .DATA_WIDTH(8), .N_DIGITS(3), .RATIO(4), .FAST_DIV(2),
    .DEBOUNCE_CYCLES(3), .BLANK_LZ(1)
  ) dut (
    .clock(clock), .reset(reset), .mode(mode), .step_btn(step_btn),
    .data_in(data_in), .cpu_tick(cpu_tick), .tick_led(tick_led),
    .hex(hex), .busy(busy)
  );

  td4_front_panel #(
    .DATA_WIDTH(8), .N_DIGITS(2), .RATIO(4), .FAST_DIV(2),
    .DEBOUNCE_CYCLES(3), .BLANK_LZ(1)
  ) dut2 (
    .clock(clock), .reset(reset), .mode(mode), .step_btn(step_btn),
    .data_in(data_in), .cpu_tick(cpu_tick2), .tick_led(tick_led2),
    .hex(hex2), .busy(busy2)
  );

  // Record the cycle number of every observed tick.
  always @(negedge clock) begin
    if (!reset) begin
      if (cpu_tick)  obs_t1.push_back(cyc);
      if (cpu_tick2) obs_t2.push_back(cyc);
    end
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic adv(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  function automatic logic [6:0] g(input int d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      5: return 7'h12;
      7: return 7'h78;
      9: return 7'h10;
      DS: return 7'h3F;
      default: return 7'h7F;
    endcase
  endfunction

  task automatic drain_ticks(input string tag);
    chk_eq({tag, "_count"}, obs_t1.size(), exp_t.size());
    chk_eq({tag, "_count2"}, obs_t2.size(), exp_t.size());
    while (exp_t.size() > 0) begin
      int e = exp_t.pop_front();
      if (obs_t1.size() > 0) chk_eq({tag, "_cyc"}, obs_t1.pop_front(), e);
      if (obs_t2.size() > 0) chk_eq({tag, "_cyc2"}, obs_t2.pop_front(), e);
    end
    obs_t1.delete();
    obs_t2.delete();
  endtask

  task automatic disp_case(input logic [7:0] v, input int a2, input int a1, input int a0,
                           input int b1, input int b0);
    data_in = v;
    exp_h1.push_back({g(a2), g(a1), g(a0)});
    exp_h2.push_back({g(b1), g(b0)});
    adv(20);
    chk_eq($sformatf("hex3_%0d", v), hex, exp_h1.pop_front());
    chk_eq($sformatf("hex2_%0d", v), hex2, exp_h2.pop_front());
  endtask

  initial begin
    reset    = 1'b1;
    mode     = 2'b00;
    step_btn = 1'b0;
    data_in  = 8'd0;
    adv(3);

    chk_eq("rst_tick", cpu_tick, 0);
    chk_eq("rst_led", tick_led, 0);
    chk_eq("rst_busy", busy, 0);
    chk_eq("rst_hex", hex, 21'h1FFFFF);
    chk_eq("rst_hex2", hex2, 14'h3FFF);

    // RUN: period 4, then FAST: period 2
    reset = 1'b0;
    mode  = 2'b10;
    t0    = cyc;
    for (int k = 4; k <= 20; k += 4) exp_t.push_back(t0 + k);
    adv(21);
    chk_eq("run_led", tick_led, 1);
    chk_eq("run_led2", tick_led2, 1);
    mode = 2'b11;
    t0   = cyc;
    exp_t.push_back(t0 + 2);
    exp_t.push_back(t0 + 4);
    adv(6);
    chk_eq("fast_led", tick_led, 1);
    drain_ticks("run_fast");

    // STEP: bounce then stable press, twice
    mode = 2'b01;
    adv(2);
    step_btn = 1'b1; adv(1);
    step_btn = 1'b0; adv(1);
    step_btn = 1'b1; adv(1);
    step_btn = 1'b0; adv(1);
    step_btn = 1'b1;
    t0 = cyc;
    exp_t.push_back(t0 + 5);
    adv(10);
    step_btn = 1'b0;
    adv(8);
    step_btn = 1'b1;
    t0 = cyc;
    exp_t.push_back(t0 + 5);
    adv(10);
    step_btn = 1'b0;
    adv(8);
    drain_ticks("step");

    // HALT: a press produces nothing
    mode = 2'b00;
    adv(1);
    step_btn = 1'b1;
    adv(12);
    step_btn = 1'b0;
    adv(8);
    drain_ticks("halt");

    // Display values
    disp_case(8'd205, 2, 0, 5, DS, DS);
    disp_case(8'd7,   BL, BL, 7, BL, 7);
    disp_case(8'd0,   BL, BL, 0, BL, 0);
    disp_case(8'd255, 2, 5, 5, DS, DS);
    disp_case(8'd99,  BL, 9, 9, 9, 9);
    disp_case(8'd100, 1, 0, 0, DS, DS);

    // Reset in the middle of a conversion
    data_in = 8'd205;
    for (int i = 0; i < 12 && busy; i++) adv(1);
    chk_eq("done_seen", busy, 0);
    adv(3);
    chk_eq("busy_mid", busy, 1);
    reset = 1'b1;
    adv(1);
    chk_eq("mid_rst_hex", hex, 21'h1FFFFF);
    chk_eq("mid_rst_hex2", hex2, 14'h3FFF);
    chk_eq("mid_rst_busy", busy, 0);
    chk_eq("mid_rst_busy2", busy2, 0);
    chk_eq("mid_rst_tick", cpu_tick, 0);
    chk_eq("mid_rst_led", tick_led, 0);
    adv(2);
    reset = 1'b0;
    exp_h1.push_back({g(2), g(0), g(5)});
    exp_h2.push_back({g(DS), g(DS)});
    adv(20);
    chk_eq("post_rst_hex", hex, exp_h1.pop_front());
    chk_eq("post_rst_hex2", hex2, exp_h2.pop_front());
    drain_ticks("tail");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
